// File: rtl/lap_stopwatch.sv
// Lap stopwatch: prescaled BCD counter with IDLE/RUN/PAUSE control and a
// small bank of lap-capture registers read back through a registered mux.
module lap_stopwatch #(
  parameter int TICK_DIV  = 1000000,
  parameter int DIGITS    = 6,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     control,
  input  logic [$clog2(LAP_DEPTH)-1:0]   lap_sel,
  output logic [4*DIGITS-1:0]            count,
  output logic [4*DIGITS-1:0]            lap_time,
  output logic [$clog2(LAP_DEPTH):0]     lap_count,
  output logic                           running,
  output logic                           overflow
);

  localparam int SW   = $clog2(LAP_DEPTH);
  localparam int CW   = SW + 1;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int CNTW = 4 * DIGITS;

  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEPTH   = CW'(LAP_DEPTH);

  localparam logic [1:0] CMD_CLEAR = 2'd0;
  localparam logic [1:0] CMD_RUN   = 2'd1;
  localparam logic [1:0] CMD_PAUSE = 2'd2;
  localparam logic [1:0] CMD_LAP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [PW-1:0]       presc_r;
  logic [CNTW-1:0]     count_r;
  logic [CNTW-1:0]     count_inc_s;
  logic                carry_s;
  logic [CW-1:0]       lap_count_r;
  logic [CNTW-1:0]     lap_time_r;
  logic [CNTW-1:0]     laps_r [LAP_DEPTH];
  logic                running_r;
  logic                overflow_r;
  logic [1:0]          ctrl_prev_r;
  logic                tick_s;
  logic                clear_s;
  logic                capture_s;

  // BCD increment; the top bit of the result is set only when every digit was 9.
  function automatic logic [CNTW:0] bcd_inc(input logic [CNTW-1:0] v);
    logic [CNTW-1:0] r;
    logic            c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return {c, r};
  endfunction

  // Next-state decode plus tick, clear and lap-capture qualifiers.
  always_comb begin
    state_s = state_r;
    case (control)
      CMD_CLEAR: state_s = IDLE;
      CMD_RUN:   state_s = RUN;
      CMD_PAUSE: begin
        if (state_r == RUN) begin
          state_s = PAUSE;
        end else begin
          state_s = state_r;
        end
      end
      CMD_LAP:   state_s = state_r;
      default:   state_s = state_r;
    endcase
    {carry_s, count_inc_s} = bcd_inc(count_r);
    tick_s    = (state_r == RUN) && (presc_r == PRE_MAX);
    clear_s   = (control == CMD_CLEAR);
    // Only a fresh lap command while running, and only while a slot is free.
    capture_s = (control == CMD_LAP) && (ctrl_prev_r != CMD_LAP) &&
                (state_r == RUN) && (lap_count_r < DEPTH);
  end

  // State, prescaler, count, lap counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      presc_r     <= '0;
      count_r     <= '0;
      lap_count_r <= '0;
      running_r   <= 1'b0;
      overflow_r  <= 1'b0;
      ctrl_prev_r <= 2'd0;
    end else begin
      ctrl_prev_r <= control;
      if (clear_s) begin
        state_r     <= IDLE;
        presc_r     <= '0;
        count_r     <= '0;
        lap_count_r <= '0;
        running_r   <= 1'b0;
        overflow_r  <= 1'b0;
      end else begin
        state_r   <= state_s;
        running_r <= (state_s == RUN);
        if (state_r == RUN) begin
          if (tick_s) begin
            presc_r    <= '0;
            count_r    <= count_inc_s;
            overflow_r <= overflow_r | carry_s;
          end else begin
            presc_r <= presc_r + PW'(1);
          end
        end
        if (capture_s) begin
          lap_count_r <= lap_count_r + CW'(1);
        end
      end
    end
  end

  // Lap storage (captures the pre-edge count) and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAP_DEPTH; i++) begin
        laps_r[i] <= '0;
      end
      lap_time_r <= '0;
    end else begin
      if (capture_s) begin
        laps_r[lap_count_r[SW-1:0]] <= count_r;
      end
      if ({1'b0, lap_sel} < lap_count_r) begin
        lap_time_r <= laps_r[lap_sel];
      end else begin
        lap_time_r <= '0;
      end
    end
  end

  assign count     = count_r;
  assign lap_time  = lap_time_r;
  assign lap_count = lap_count_r;
  assign running   = running_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: vector table on a TICK_DIV=4 instance, then
// reset and digit-carry/overflow sequences on TICK_DIV=2 instances.
module tb_lap_stopwatch;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ctrl_a;
  logic [1:0]  sel_a;
  logic [23:0] count_a;
  logic [23:0] lt_a;
  logic [2:0]  lc_a;
  logic        run_a;
  logic        ov_a;

  logic [1:0]  ctrl_bc;
  logic [1:0]  sel_bc;
  logic [23:0] count_b;
  logic [23:0] lt_b;
  logic [2:0]  lc_b;
  logic        run_b;
  logic        ov_b;
  logic [7:0]  count_c;
  logic [7:0]  lt_c;
  logic [2:0]  lc_c;
  logic        run_c;
  logic        ov_c;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [1:0]  ctrl;
    logic [1:0]  sel;
    int          cycles;
    logic [23:0] cnt;
    logic [23:0] lt;
    logic [2:0]  lc;
    logic        run;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [23:0] cb;
    logic [7:0]  cc;
    logic        runb;
    logic        runc;
    logic        ovb;
    logic        ovc;
  } bc_t;

  vec_t vq[$];
  vec_t exp_q[$];
  bc_t  bc_q[$];
  vec_t e;
  bc_t  eb;

  lap_stopwatch #(.TICK_DIV(4), .DIGITS(6), .LAP_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .control(ctrl_a), .lap_sel(sel_a),
    .count(count_a), .lap_time(lt_a), .lap_count(lc_a),
    .running(run_a), .overflow(ov_a));

  lap_stopwatch #(.TICK_DIV(2), .DIGITS(6), .LAP_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .control(ctrl_bc), .lap_sel(sel_bc),
    .count(count_b), .lap_time(lt_b), .lap_count(lc_b),
    .running(run_b), .overflow(ov_b));

  lap_stopwatch #(.TICK_DIV(2), .DIGITS(2), .LAP_DEPTH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .control(ctrl_bc), .lap_sel(sel_bc),
    .count(count_c), .lap_time(lt_c), .lap_count(lc_c),
    .running(run_c), .overflow(ov_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_a(input int idx, input vec_t x);
    n_vec++;
    chk("count",     idx, 32'(count_a), 32'(x.cnt));
    chk("lap_time",  idx, 32'(lt_a),    32'(x.lt));
    chk("lap_count", idx, 32'(lc_a),    32'(x.lc));
    chk("running",   idx, 32'(run_a),   32'(x.run));
    chk("overflow",  idx, 32'(ov_a),    32'(x.ov));
  endtask

  task automatic check_bc(input int idx, input bc_t x);
    n_vec++;
    chk("count_b",    idx, 32'(count_b), 32'(x.cb));
    chk("count_c",    idx, 32'(count_c), 32'(x.cc));
    chk("running_b",  idx, 32'(run_b),   32'(x.runb));
    chk("running_c",  idx, 32'(run_c),   32'(x.runc));
    chk("overflow_b", idx, 32'(ov_b),    32'(x.ovb));
    chk("overflow_c", idx, 32'(ov_c),    32'(x.ovc));
    chk("laps_b",     idx, 32'({lc_b, lt_b}), 32'd0);
    chk("laps_c",     idx, 32'({lc_c, lt_c}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n   = 1'b0;
    ctrl_a  = 2'd0;
    sel_a   = 2'd0;
    ctrl_bc = 2'd0;
    sel_bc  = 2'd0;

    //            ctrl  sel  cyc  count     lap_time  lc    run   ov
    vq.push_back('{2'd0, 2'd0, 2,  24'h0,    24'h0,    3'd0, 1'b0, 1'b0});
    vq.push_back('{2'd1, 2'd0, 41, 24'h10,   24'h0,    3'd0, 1'b1, 1'b0});
    vq.push_back('{2'd2, 2'd0, 5,  24'h10,   24'h0,    3'd0, 1'b0, 1'b0});
    vq.push_back('{2'd0, 2'd0, 1,  24'h0,    24'h0,    3'd0, 1'b0, 1'b0});
    vq.push_back('{2'd1, 2'd0, 7,  24'h1,    24'h0,    3'd0, 1'b1, 1'b0});
    vq.push_back('{2'd2, 2'd0, 20, 24'h1,    24'h0,    3'd0, 1'b0, 1'b0});
    vq.push_back('{2'd1, 2'd0, 2,  24'h2,    24'h0,    3'd0, 1'b1, 1'b0});
    vq.push_back('{2'd0, 2'd0, 1,  24'h0,    24'h0,    3'd0, 1'b0, 1'b0});
    vq.push_back('{2'd1, 2'd0, 1,  24'h0,    24'h0,    3'd0, 1'b1, 1'b0});
    vq.push_back('{2'd1, 2'd0, 12, 24'h3,    24'h0,    3'd0, 1'b1, 1'b0});
    vq.push_back('{2'd3, 2'd0, 1,  24'h3,    24'h0,    3'd1, 1'b1, 1'b0});
    vq.push_back('{2'd1, 2'd0, 15, 24'h7,    24'h3,    3'd1, 1'b1, 1'b0});
    vq.push_back('{2'd3, 2'd0, 1,  24'h7,    24'h3,    3'd2, 1'b1, 1'b0});
    vq.push_back('{2'd1, 2'd1, 7,  24'h9,    24'h7,    3'd2, 1'b1, 1'b0});
    vq.push_back('{2'd3, 2'd1, 1,  24'h9,    24'h7,    3'd3, 1'b1, 1'b0});
    vq.push_back('{2'd1, 2'd2, 11, 24'h12,   24'h9,    3'd3, 1'b1, 1'b0});
    vq.push_back('{2'd3, 2'd3, 1,  24'h12,   24'h0,    3'd4, 1'b1, 1'b0});
    vq.push_back('{2'd1, 2'd3, 1,  24'h12,   24'h12,   3'd4, 1'b1, 1'b0});
    vq.push_back('{2'd3, 2'd3, 1,  24'h12,   24'h12,   3'd4, 1'b1, 1'b0});
    vq.push_back('{2'd1, 2'd3, 1,  24'h13,   24'h12,   3'd4, 1'b1, 1'b0});
    vq.push_back('{2'd0, 2'd0, 2,  24'h0,    24'h0,    3'd0, 1'b0, 1'b0});
    vq.push_back('{2'd3, 2'd0, 2,  24'h0,    24'h0,    3'd0, 1'b0, 1'b0});
    vq.push_back('{2'd1, 2'd0, 1,  24'h0,    24'h0,    3'd0, 1'b1, 1'b0});
    vq.push_back('{2'd1, 2'd0, 7,  24'h1,    24'h0,    3'd0, 1'b1, 1'b0});
    vq.push_back('{2'd3, 2'd0, 1,  24'h2,    24'h0,    3'd1, 1'b1, 1'b0});
    vq.push_back('{2'd1, 2'd0, 1,  24'h2,    24'h1,    3'd1, 1'b1, 1'b0});
    vq.push_back('{2'd3, 2'd3, 10, 24'h4,    24'h0,    3'd2, 1'b1, 1'b0});
    vq.push_back('{2'd1, 2'd1, 1,  24'h5,    24'h2,    3'd2, 1'b1, 1'b0});
    vq.push_back('{2'd2, 2'd1, 1,  24'h5,    24'h2,    3'd2, 1'b0, 1'b0});
    vq.push_back('{2'd3, 2'd1, 3,  24'h5,    24'h2,    3'd2, 1'b0, 1'b0});
    vq.push_back('{2'd1, 2'd1, 1,  24'h5,    24'h2,    3'd2, 1'b1, 1'b0});
    vq.push_back('{2'd3, 2'd1, 1,  24'h5,    24'h2,    3'd3, 1'b1, 1'b0});

    // Reset state before any clock edge.
    #2;
    exp_q.push_back('{2'd0, 2'd0, 0, 24'h0, 24'h0, 3'd0, 1'b0, 1'b0});
    check_a(-1, exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    for (int i = 0; i < vq.size(); i++) begin
      ctrl_a = vq[i].ctrl;
      sel_a  = vq[i].sel;
      exp_q.push_back(vq[i]);
      step(vq[i].cycles);
      e = exp_q.pop_front();
      check_a(i, e);
    end

    // Asynchronous reset mid-RUN with a partial prescaler count pending.
    ctrl_a = 2'd1;
    step(1);
    #2;
    rst_n = 1'b0;
    exp_q.push_back('{2'd1, 2'd1, 0, 24'h0, 24'h0, 3'd0, 1'b0, 1'b0});
    #1;
    check_a(100, exp_q.pop_front());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{2'd1, 2'd1, 1, 24'h0, 24'h0, 3'd0, 1'b1, 1'b0});
    step(1);
    check_a(101, exp_q.pop_front());
    exp_q.push_back('{2'd1, 2'd1, 3, 24'h0, 24'h0, 3'd0, 1'b1, 1'b0});
    step(3);
    check_a(102, exp_q.pop_front());
    exp_q.push_back('{2'd1, 2'd1, 1, 24'h1, 24'h0, 3'd0, 1'b1, 1'b0});
    step(1);
    check_a(103, exp_q.pop_front());

    // Digit carry on six digits and wrap/overflow on two digits.
    ctrl_bc = 2'd1;
    bc_q.push_back('{24'h99, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0});
    step(199);
    eb = bc_q.pop_front();
    check_bc(200, eb);
    bc_q.push_back('{24'h100, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1});
    step(2);
    eb = bc_q.pop_front();
    check_bc(201, eb);
    bc_q.push_back('{24'h100, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1});
    step(1);
    eb = bc_q.pop_front();
    check_bc(202, eb);
    ctrl_bc = 2'd0;
    bc_q.push_back('{24'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    step(1);
    eb = bc_q.pop_front();
    check_bc(203, eb);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch.md
LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 Parameter TICK_DIV, default 1000000, SHALL set clk cycles per count increment (100 MHz -> 0.01 s); legal range >= 2.
REQ-002 Parameter DIGITS, default 6, SHALL set the number of BCD digits in the count; legal range 1-8.
REQ-003 Parameter LAP_DEPTH, default 4, SHALL set the number of lap-capture registers; legal range 2-16.
REQ-004 clk  input  1  SHALL be the single rising-edge clock for all state.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 control  input  2  SHALL be a level command: 0 clear, 1 run, 2 pause, 3 lap.
REQ-007 lap_sel  input  clog2(LAP_DEPTH)  SHALL select the lap register to read.
REQ-008 count  output  4*DIGITS  SHALL be the live BCD count, with digit 0 in bits [3:0].
REQ-009 lap_time  output  4*DIGITS  SHALL be the registered BCD content of lap register lap_sel.
REQ-010 lap_count  output  clog2(LAP_DEPTH)+1  SHALL be the number of laps stored.
REQ-011 running  output  1  SHALL be high while in state RUN.
REQ-012 overflow  output  1  SHALL be the sticky count wrap flag.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-014 control=0 in any state SHALL, on the next edge, enter IDLE and zero count, prescaler, lap_count and overflow; lap registers need not be cleared.
REQ-015 control=1 SHALL enter RUN from IDLE or PAUSE, and RUN SHALL hold.
REQ-016 control=2 SHALL enter PAUSE from RUN; IDLE and PAUSE SHALL hold.
REQ-017 control=3 SHALL cause no state transition.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 in RUN only, SHALL hold its value in PAUSE, and SHALL wrap to 0 at TICK_DIV-1 with a one-cycle internal tick.
REQ-019 A tick SHALL increment count as a BCD number; each digit SHALL carry at 9->0; count SHALL change on the same edge that wraps the prescaler.
REQ-020 The first count change after entering RUN from IDLE SHALL occur exactly TICK_DIV edges after the transition edge.
REQ-021 A tick when count is all 9s SHALL wrap count to 0 and set overflow; overflow SHALL stay set until control=0 or reset.
REQ-022 A lap capture SHALL occur only on the first edge at which control==3, the previous-cycle control!=3, and state==RUN; holding control at 3 SHALL NOT recapture.
REQ-023 A capture SHALL write the pre-edge count value into lap register index lap_count and increment lap_count.
REQ-024 If a tick and a capture occur on the same edge, the stored lap SHALL be the pre-increment value.
REQ-025 A capture request when lap_count==LAP_DEPTH SHALL be dropped, leaving registers and lap_count unchanged.
REQ-026 lap_time SHALL reflect lap_sel one cycle after lap_sel is applied.
REQ-027 lap_time SHALL be 0 whenever lap_sel >= lap_count.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst_n low SHALL immediately, without waiting for clk, force IDLE, count=0, lap_time=0, lap_count=0, running=0, overflow=0, prescaler=0, and control history=0.
REQ-030 Reset asserted mid-RUN SHALL discard any partial prescaler count.
REQ-031 After rst_n deasserts, the first state change SHALL occur on the first clk edge at which rst_n is high.

Verification
REQ-032 Basic counting (TICK_DIV=4): control=1 for 40 cycles -> count=0x000010, running=1; then control=2 -> count frozen at 0x000010, running=0.
REQ-033 Pause and resume (TICK_DIV=4): run 6 cycles, pause 20 cycles, run 2 cycles -> count=0x000002, showing the prescaler residue was kept across PAUSE.
REQ-034 Digit carry (TICK_DIV=2): run to count 0x000099, then one more tick -> count=0x000100; run a DIGITS=2 instance past 0x99 -> count=0x00, overflow=1; then control=0 -> overflow=0.
REQ-035 Lap capture (TICK_DIV=4, LAP_DEPTH=4):
- capture at counts 3, 7, 9 and 12, then capture a 5th time -> lap_count=4, and lap_sel 0..3 read 0x3, 0x7, 0x9, 0x12;
- holding control=3 for 10 cycles -> exactly one capture.
REQ-036 Lap edge cases:
- a capture coincident with a tick stores the old value;
- a capture attempted in PAUSE or IDLE is ignored;
- lap_sel=3 with lap_count=2 -> lap_time=0.
REQ-037 Asynchronous reset: pull rst_n low between clk edges during RUN -> all outputs 0 before the next edge; after release, control=1 gives the first increment TICK_DIV edges later.
